// File: rtl/i2s_pkg.sv
// Shared widths and sample types for the I2S transmitter.
package i2s_pkg;
  localparam int DSP_W      = 32;
  localparam int SAMPLE_W   = 24;
  localparam int SLOT_W     = 32;
  localparam int FRAME_BITS = 64;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int POS_W      = $clog2(SLOT_W);

  typedef logic signed [DSP_W-1:0]    dsp_word_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/i2s_if.sv
// Sample stream from the filter into the I2S transmitter (valid/ready).
interface i2s_if;
  import i2s_pkg::*;

  logic      s_valid;
  logic      s_ready;
  dsp_word_t s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/i2s_clkgen.sv
// Bit-clock generator: divides clk down to bclk and flags the cycle whose
// closing edge takes bclk from 1 to 0.
module i2s_clkgen #(
  parameter int BCLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_bclk,
  output logic o_fall
);
  localparam int              DIV_W = 8;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_bclk;
  logic             w_wrap;

  assign w_wrap = (r_div == LAST);

  // Half-period divider; bclk toggles each time the divider wraps
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (w_wrap) begin
      r_div  <= '0;
      r_bclk <= ~r_bclk;
    end else begin
      r_div  <= r_div + DIV_W'(1);
    end
  end

  assign o_bclk = r_bclk;
  assign o_fall = w_wrap && r_bclk;
endmodule

// File: rtl/i2s_tx.sv
// Mono I2S transmitter: one-entry sample buffer, 32->24 bit conversion,
// 64-bit frame counter and serial shifter. The same sample goes out on both
// left and right slots.
// Optional build macro: I2S_TX_SATURATE_EN clamps the shifted sample to the
// 24-bit signed range instead of wrapping.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 4,
  parameter int SHIFT    = 8
) (
  input  logic clk,
  input  logic reset,
  i2s_if.slave s,
  output logic bclk,
  output logic lrck,
  output logic sdata,
  output logic underrun
);

`ifdef I2S_TX_SATURATE_EN
  localparam dsp_word_t SAT_MAX = 32'sh007F_FFFF;
  localparam dsp_word_t SAT_MIN = 32'shFF80_0000;
`endif

  logic             w_fall;
  logic             w_frame_start;
  logic             w_xfer;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic             r_full;
  dsp_word_t        r_buf;
  sample_t          r_frame;
  logic             r_sdata;
  logic             r_underrun;

  // Arithmetic shift down to the DAC range, then wrap or clamp to 24 bits
  function automatic sample_t f_convert(input dsp_word_t din);
    dsp_word_t v_sh;
    v_sh = din >>> SHIFT;
`ifdef I2S_TX_SATURATE_EN
    if (v_sh > SAT_MAX)      return sample_t'(SAT_MAX[SAMPLE_W-1:0]);
    else if (v_sh < SAT_MIN) return sample_t'(SAT_MIN[SAMPLE_W-1:0]);
    else                     return sample_t'(v_sh[SAMPLE_W-1:0]);
`else
    return sample_t'(v_sh[SAMPLE_W-1:0]);
`endif
  endfunction

  // Bit driven at slot position p: p=0 is the I2S one-bit delay, p=1..24
  // walk the sample MSB first, the remaining positions pad with zero
  function automatic logic f_slot_bit(input sample_t frame, input logic [POS_W-1:0] p);
    logic [POS_W-1:0] v_idx;
    v_idx = '0;
    f_slot_bit = 1'b0;
    if (p != '0 && p <= POS_W'(SAMPLE_W)) begin
      v_idx      = POS_W'(SAMPLE_W) - p;
      f_slot_bit = frame[v_idx];
    end
  endfunction

  i2s_clkgen #(.BCLK_DIV(BCLK_DIV)) u_clkgen (
    .i_clk  (clk),
    .i_rst  (reset),
    .o_bclk (bclk),
    .o_fall (w_fall)
  );

  assign w_cnt_nxt     = r_cnt + CNT_W'(1);
  assign w_frame_start = w_fall && (r_cnt == '1);
  assign s.s_ready     = !r_full && !reset;
  assign w_xfer        = s.s_valid && s.s_ready;

  // Frame control: bit counter, buffer occupancy, frame load, serial output
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_full     <= 1'b0;
      r_frame    <= '0;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_frame_start && !r_full;
      if (w_fall) begin
        r_cnt   <= w_cnt_nxt;
        r_sdata <= f_slot_bit(r_frame, w_cnt_nxt[POS_W-1:0]);
      end
      if (w_frame_start) begin
        r_frame <= r_full ? f_convert(r_buf) : '0;
      end
      // Transfer and frame-start drain never coincide with a full buffer,
      // so a transfer always wins the occupancy flag
      if (w_xfer) begin
        r_full <= 1'b1;
      end else if (w_frame_start) begin
        r_full <= 1'b0;
      end
    end
  end

  // Sample word capture; only meaningful while r_full is set
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_buf <= s.s_data;
    end
  end

  assign lrck     = r_cnt[CNT_W-1];
  assign sdata    = r_sdata;
  assign underrun = r_underrun;
endmodule
